// File: rtl/audio_codec_pkg.sv
// Shared types and constants for the codec serial-port capture and playback paths.
package audio_codec_pkg;

  localparam int AUDIO_DATA_W = 16;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    RX_LEFT,
    RX_RIGHT
  } rx_state_t;

endpackage

// File: rtl/audio_codec_adc_rx_if.sv
// Parallel sample handshake and status flags between the ADC receiver and the DSP side.
interface audio_codec_adc_rx_if #(
  parameter int DATA_W = audio_codec_pkg::AUDIO_DATA_W
);
  logic [DATA_W-1:0] sample_left;
  logic [DATA_W-1:0] sample_right;
  logic              sample_valid;
  logic              sample_ready;
  logic              overrun;
  logic              overrun_clr;
  logic              frame_err;

  modport master (
    output sample_left, sample_right, sample_valid, overrun, frame_err,
    input  sample_ready, overrun_clr
  );

  modport slave (
    input  sample_left, sample_right, sample_valid, overrun, frame_err,
    output sample_ready, overrun_clr
  );
endinterface

// File: rtl/audio_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level with a one-cycle rising-edge pulse.
module audio_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;
endmodule

// File: rtl/audio_codec_adc_rx.sv
// Codec ADC serial-port receiver: deserializes MSB-first stereo frames (I2S or
// left-justified) clocked by the codec's BCLK into a held left/right pair.
module audio_codec_adc_rx
  import audio_codec_pkg::*;
#(
  parameter int DATA_W      = AUDIO_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter bit I2S_MODE    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bclk,
  input  logic                 adclrc,
  input  logic                 adcdat,
  audio_codec_adc_rx_if.master rx
);
  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic bclk_rise;

  audio_sync_edge #(.STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bclk),
    .rise (bclk_rise)
  );

  logic [SYNC_STAGES-1:0] lrc_sync_q, lrc_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  rx_state_t              state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   skip_q, skip_d;
  logic                   lrc_prev_q, lrc_prev_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [DATA_W-1:0]      left_q, left_d;
  logic [DATA_W-1:0]      out_left_q, out_left_d;
  logic [DATA_W-1:0]      out_right_q, out_right_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;

  logic             lrc_s, dat_s, lrc_edge, start_chan, pair_done;
  logic [CNT_W-1:0] cnt_sel;
  logic             skip_sel;

  assign lrc_s = lrc_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  always_comb begin
    lrc_sync_d  = {lrc_sync_q[SYNC_STAGES-2:0], adclrc};
    dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], adcdat};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    skip_d      = skip_q;
    lrc_prev_d  = lrc_prev_q;
    shift_d     = shift_q;
    left_d      = left_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    lrc_edge    = 1'b0;
    start_chan  = 1'b0;
    pair_done   = 1'b0;
    cnt_sel     = bit_cnt_q;
    skip_sel    = skip_q;

    if (bclk_rise) begin
      lrc_prev_d = lrc_s;
      lrc_edge   = (lrc_s != lrc_prev_q);
      case (state_q)
        WAIT_FRAME: begin
          if (lrc_edge && !lrc_s) begin
            state_d    = RX_LEFT;
            start_chan = 1'b1;
          end
        end
        RX_LEFT: begin
          if (lrc_edge && lrc_s) begin
            if (bit_cnt_q == CNT_FULL) begin
              left_d     = shift_q;
              state_d    = RX_RIGHT;
              start_chan = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_FRAME;
            end
          end
        end
        RX_RIGHT: begin
          if (lrc_edge && !lrc_s) begin
            if (bit_cnt_q == CNT_FULL) pair_done = 1'b1;
            else                       frame_err_d = 1'b1;
            state_d    = RX_LEFT;
            start_chan = 1'b1;
          end
        end
        default: state_d = WAIT_FRAME;
      endcase

      // The edge bit itself belongs to the new channel: skipped in I2S, MSB otherwise.
      if (start_chan) begin
        cnt_sel  = '0;
        skip_sel = I2S_MODE;
      end
      if (state_d != WAIT_FRAME) begin
        bit_cnt_d = cnt_sel;
        skip_d    = skip_sel;
        if (skip_sel) begin
          skip_d = 1'b0;
        end else if (cnt_sel < CNT_FULL) begin
          shift_d   = {shift_q[DATA_W-2:0], dat_s};
          bit_cnt_d = cnt_sel + CNT_W'(1);
        end
      end
    end

    if (pair_done) begin
      if (!valid_q || rx.sample_ready) begin
        out_left_d  = left_q;
        out_right_d = shift_q;
        valid_d     = 1'b1;
      end
    end else if (valid_q && rx.sample_ready) begin
      valid_d = 1'b0;
    end

    if (rx.overrun_clr) overrun_d = 1'b0;
    if (pair_done && valid_q && !rx.sample_ready) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lrc_sync_q  <= '0;
      dat_sync_q  <= '0;
      state_q     <= WAIT_FRAME;
      bit_cnt_q   <= '0;
      skip_q      <= 1'b0;
      lrc_prev_q  <= 1'b0;
      shift_q     <= '0;
      left_q      <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      lrc_sync_q  <= lrc_sync_d;
      dat_sync_q  <= dat_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      skip_q      <= skip_d;
      lrc_prev_q  <= lrc_prev_d;
      shift_q     <= shift_d;
      left_q      <= left_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx.sample_left  = out_left_q;
  assign rx.sample_right = out_right_q;
  assign rx.sample_valid = valid_q;
  assign rx.overrun      = overrun_q;
  assign rx.frame_err    = frame_err_q;
endmodule

// File: tb/tb_audio_codec_adc_rx.sv
// Scoreboard bench for audio_codec_adc_rx: one I2S instance and one left-justified
// instance share the serial lines; the idle one is held in reset.
module tb_audio_codec_adc_rx;
  import audio_codec_pkg::*;

  localparam int W    = AUDIO_DATA_W;
  localparam int HALF = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a, rst_n_b;
  logic bclk, adclrc, adcdat;

  audio_codec_adc_rx_if #(.DATA_W(W)) if_a ();
  audio_codec_adc_rx_if #(.DATA_W(W)) if_b ();

  audio_codec_adc_rx #(.DATA_W(W), .SYNC_STAGES(2), .I2S_MODE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bclk(bclk), .adclrc(adclrc), .adcdat(adcdat), .rx(if_a.master)
  );
  audio_codec_adc_rx #(.DATA_W(W), .SYNC_STAGES(2), .I2S_MODE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bclk(bclk), .adclrc(adclrc), .adcdat(adcdat), .rx(if_b.master)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          xfer_a = 0, xfer_b = 0, ferr_a = 0, ferr_b = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  bit          toggle_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Monitors sample just before each rising clk edge, where a transfer is decided.
  initial forever begin
    @(negedge clk); #4;
    if (if_a.frame_err) ferr_a++;
    if (if_a.sample_valid && if_a.sample_ready) begin
      xfer_a++;
      if (exp_a.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL a_unexpected_pair: actual %h required none", {if_a.sample_left, if_a.sample_right});
      end else begin
        check("a_pair", {if_a.sample_left, if_a.sample_right}, exp_a.pop_front());
        $display("a transfer L=%h R=%h", if_a.sample_left, if_a.sample_right);
      end
    end
  end

  initial forever begin
    @(negedge clk); #4;
    if (if_b.frame_err) ferr_b++;
    if (if_b.sample_valid && if_b.sample_ready) begin
      xfer_b++;
      if (exp_b.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL b_unexpected_pair: actual %h required none", {if_b.sample_left, if_b.sample_right});
      end else begin
        check("b_pair", {if_b.sample_left, if_b.sample_right}, exp_b.pop_front());
        $display("b transfer L=%h R=%h", if_b.sample_left, if_b.sample_right);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (toggle_b) if_b.sample_ready = ~if_b.sample_ready;
  end

  task automatic bit_t(input logic lrc, input logic dat);
    bclk = 1'b0; adclrc = lrc; adcdat = dat;
    repeat (HALF) @(negedge clk);
    bclk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Slots first..last-1 of one channel; in I2S the MSB sits in slot 1.
  task automatic chan(input logic lrc, input logic [15:0] w, input int first, input int last, input bit i2s);
    for (int k = first; k < last; k++) begin
      int   idx;
      logic d;
      idx = i2s ? k - 1 : k;
      d   = (idx >= 0 && idx < W) ? w[W-1-idx] : 1'b0;
      bit_t(lrc, d);
    end
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r, input int n, input bit i2s);
    chan(1'b0, l, 0, n, i2s);
    chan(1'b1, r, 0, n, i2s);
  endtask

  task automatic flush();
    repeat (4) bit_t(1'b0, 1'b0);
    repeat (20) @(negedge clk);
  endtask

  task automatic reset_a();
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n_a = 1'b1;
    xfer_a = 0; ferr_a = 0;
  endtask

  initial begin
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    bclk = 1'b0; adclrc = 1'b0; adcdat = 1'b0;
    if_a.sample_ready = 1'b0; if_a.overrun_clr = 1'b0;
    if_b.sample_ready = 1'b0; if_b.overrun_clr = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_valid",     if_a.sample_valid, 0);
    check("rst_left",      if_a.sample_left, 0);
    check("rst_right",     if_a.sample_right, 0);
    check("rst_overrun",   if_a.overrun, 0);
    check("rst_frame_err", if_a.frame_err, 0);
    check("rst_b_valid",   if_b.sample_valid, 0);

    // 1) I2S, 32 BCLK per channel
    reset_a();
    if_a.sample_ready = 1'b1;
    repeat (4) bit_t(1'b1, 1'b0);
    exp_a.push_back(32'hA5C3_5A3C);
    frame(16'hA5C3, 16'h5A3C, 32, 1'b1);
    flush();
    check("t1_transfers", xfer_a, 1);
    check("t1_queue", exp_a.size(), 0);
    check("t1_frame_err", ferr_a, 0);

    // 2) reset released mid right channel
    rst_n_a = 1'b0;
    xfer_a = 0;
    chan(1'b0, 16'h1111, 0, 32, 1'b1);
    chan(1'b1, 16'h2222, 0, 10, 1'b1);
    rst_n_a = 1'b1;
    chan(1'b1, 16'h2222, 10, 32, 1'b1);
    exp_a.push_back(32'h1357_9BDF);
    frame(16'h1357, 16'h9BDF, 32, 1'b1);
    exp_a.push_back(32'h0246_8ACE);
    frame(16'h0246, 16'h8ACE, 32, 1'b1);
    flush();
    check("t2_transfers", xfer_a, 2);
    check("t2_queue", exp_a.size(), 0);

    // 3) consumer stalled across two frames
    reset_a();
    if_a.sample_ready = 1'b0;
    repeat (4) bit_t(1'b1, 1'b0);
    frame(16'h1234, 16'h5678, 32, 1'b1);
    frame(16'h9ABC, 16'hDEF0, 32, 1'b1);
    flush();
    check("t3_valid_held", if_a.sample_valid, 1);
    check("t3_left_held",  if_a.sample_left, 32'h1234);
    check("t3_right_held", if_a.sample_right, 32'h5678);
    check("t3_overrun",    if_a.overrun, 1);
    if_a.overrun_clr = 1'b1;
    @(negedge clk);
    if_a.overrun_clr = 1'b0;
    @(negedge clk);
    check("t3_overrun_clr", if_a.overrun, 0);
    exp_a.push_back(32'h1234_5678);
    if_a.sample_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("t3_transfers", xfer_a, 1);
    check("t3_queue", exp_a.size(), 0);

    // 4) short left channel
    reset_a();
    repeat (4) bit_t(1'b1, 1'b0);
    chan(1'b0, 16'h1111, 0, 10, 1'b1);
    chan(1'b1, 16'h2222, 0, 32, 1'b1);
    exp_a.push_back(32'hCAFE_BEEF);
    frame(16'hCAFE, 16'hBEEF, 32, 1'b1);
    flush();
    check("t4_frame_err", ferr_a, 1);
    check("t4_transfers", xfer_a, 1);
    check("t4_queue", exp_a.size(), 0);

    // 5) left-justified, 16 BCLK per channel, ready toggling every clk
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n_b = 1'b1;
    toggle_b = 1'b1;
    repeat (4) bit_t(1'b1, 1'b0);
    exp_b.push_back(32'h8001_7FFE); frame(16'h8001, 16'h7FFE, 16, 1'b0);
    exp_b.push_back(32'h1357_2468); frame(16'h1357, 16'h2468, 16, 1'b0);
    exp_b.push_back(32'hFFFF_0000); frame(16'hFFFF, 16'h0000, 16, 1'b0);
    exp_b.push_back(32'h8001_7FFE); frame(16'h8001, 16'h7FFE, 16, 1'b0);
    flush();
    toggle_b = 1'b0;
    check("t5_transfers", xfer_b, 4);
    check("t5_overrun", if_b.overrun, 0);
    check("t5_queue", exp_b.size(), 0);
    check("t5_frame_err", ferr_b, 0);

    // 6) ready rises in the very cycle the next pair completes
    reset_a();
    if_a.sample_ready = 1'b0;
    repeat (4) bit_t(1'b1, 1'b0);
    exp_a.push_back(32'h0F0F_F0F0);
    frame(16'h0F0F, 16'hF0F0, 32, 1'b1);
    exp_a.push_back(32'h3C3C_C3C3);
    frame(16'h3C3C, 16'hC3C3, 32, 1'b1);
    bclk = 1'b0; adclrc = 1'b0; adcdat = 1'b0;
    repeat (HALF) @(negedge clk);
    bclk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if_a.sample_ready = 1'b1;
    @(negedge clk);
    check("t6_valid_stays", if_a.sample_valid, 1);
    check("t6_new_left",    if_a.sample_left, 32'h3C3C);
    check("t6_new_right",   if_a.sample_right, 32'hC3C3);
    check("t6_overrun",     if_a.overrun, 0);
    repeat (HALF - 3) @(negedge clk);
    flush();
    check("t6_transfers", xfer_a, 2);
    check("t6_queue", exp_a.size(), 0);
    check("t6_overrun_end", if_a.overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
